// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the interrupt controller.
//   - irq_state_e : controller state encodings (IDLE / REQ / SVC)
//   - ID_W        : width of the source index presented to fetch
//   - DEF_VEC_BASE / DEF_VEC_STRIDE : default vector table placement
package irq_ctrl_pkg;

    localparam int unsigned ID_W = 4;

    localparam logic [15:0] DEF_VEC_BASE   = 16'h0040;
    localparam logic [15:0] DEF_VEC_STRIDE = 16'h0004;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest index wins.
//   req : N-wide request vector
//   any : at least one request bit set
//   id  : index of the winning request (0 when any == 0)
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]    req,
    output logic            any,
    output logic [ID_W-1:0] id
);

    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                any = 1'b1;
                id  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source vectored interrupt controller feeding the fetch stage.
//   clk, rst      : clock, asynchronous active-low reset
//   src_int       : raw interrupt lines (edge or level per EDGE_MASK)
//   src_ack       : one-cycle acknowledge to the serviced source
//   mask_we/wdata : enable-mask write port (1 = enabled)
//   int_req/id/vec: vectored request to fetch, frozen while pending
//   int_take      : fetch redirects to int_vec; take_pc is the resume PC
//   iret          : return-from-interrupt retired
//   ret_pc        : saved resume PC (epc)
//   in_service    : handler active, no nesting
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned          NUM_SRC    = 4,
    parameter int unsigned          PC_W       = 16,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK  = NUM_SRC'(1),
    parameter logic [PC_W-1:0]      VEC_BASE   = PC_W'(DEF_VEC_BASE),
    parameter logic [PC_W-1:0]      VEC_STRIDE = PC_W'(DEF_VEC_STRIDE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  src_int,
    output logic [NUM_SRC-1:0]  src_ack,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    output logic                int_req,
    output logic [ID_W-1:0]     int_id,
    output logic [PC_W-1:0]     int_vec,
    input  logic                int_take,
    input  logic [PC_W-1:0]     take_pc,
    input  logic                iret,
    output logic [PC_W-1:0]     ret_pc,
    output logic                in_service
);

    irq_state_e         state_q;
    logic [NUM_SRC-1:0] hist_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] ack_q;
    logic [ID_W-1:0]    id_q;
    logic [PC_W-1:0]    vec_q;
    logic [PC_W-1:0]    epc_q;
    logic               req_q;
    logic               svc_q;

    logic               win_any;
    logic [ID_W-1:0]    win_id;
    logic               take_fire;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pend_d;

    irq_prio_enc #(
        .N (NUM_SRC)
    ) u_prio (
        .req (pend_q & mask_q),
        .any (win_any),
        .id  (win_id)
    );

    // int_take is only honoured while a request is outstanding.
    assign take_fire = (state_q == IRQ_REQ) && int_take;

    // Edge sources: a fresh rising edge beats the take-time clear.
    // Level sources: pending is just the registered line.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            clr[i] = take_fire && (id_q == ID_W'(i));
        end
        pend_d = (((src_int & ~hist_q) | (pend_q & ~clr)) & EDGE_MASK)
               | (src_int & ~EDGE_MASK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            epc_q  <= '0;
        end else begin
            hist_q <= src_int;
            pend_q <= pend_d;
            if (mask_we) mask_q <= mask_wdata;
            if (take_fire) epc_q <= take_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IRQ_IDLE;
            id_q    <= '0;
            vec_q   <= '0;
            req_q   <= 1'b0;
            svc_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            ack_q <= clr;
            case (state_q)
                IRQ_IDLE: begin
                    if (win_any) begin
                        state_q <= IRQ_REQ;
                        req_q   <= 1'b1;
                        id_q    <= win_id;
                        vec_q   <= VEC_BASE + PC_W'(win_id) * VEC_STRIDE;
                    end
                end
                IRQ_REQ: begin
                    if (int_take) begin
                        state_q <= IRQ_SVC;
                        req_q   <= 1'b0;
                        svc_q   <= 1'b1;
                    end
                end
                IRQ_SVC: begin
                    if (iret) begin
                        state_q <= IRQ_IDLE;
                        svc_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    req_q   <= 1'b0;
                    svc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign src_ack    = ack_q;
    assign int_req    = req_q;
    assign int_id     = id_q;
    assign int_vec    = vec_q;
    assign ret_pc     = epc_q;
    assign in_service = svc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

    localparam int unsigned NS   = 4;
    localparam bit [3:0]    EDGE = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_int;
    logic [3:0]  src_ack;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_req;
    logic [3:0]  int_id;
    logic [15:0] int_vec;
    logic        int_take;
    logic [15:0] take_pc;
    logic        iret;
    logic [15:0] ret_pc;
    logic        in_service;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_SRC   (4),
        .PC_W      (16),
        .EDGE_MASK (EDGE),
        .VEC_BASE  (16'h0040),
        .VEC_STRIDE(16'h0004)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_int   (src_int),
        .src_ack   (src_ack),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_vec   (int_vec),
        .int_take  (int_take),
        .take_pc   (take_pc),
        .iret      (iret),
        .ret_pc    (ret_pc),
        .in_service(in_service)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = nothing outstanding, 1 = request waiting
    // for fetch, 2 = handler running.
    int       m_mode;
    bit       m_hist [NS];
    bit       m_pend [NS];
    bit [3:0] m_mask;
    int       m_id;
    int       m_epc;
    bit [3:0] m_ack;
    bit       m_take;
    int       m_win;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0;
            m_mask = '0;
            m_id   = 0;
            m_epc  = 0;
            m_ack  = '0;
            for (int i = 0; i < NS; i++) begin
                m_hist[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
        end else begin
            m_take = (m_mode == 1) && int_take;
            m_ack  = m_take ? 4'(1 << m_id) : 4'b0000;
            m_win  = -1;
            for (int i = 0; i < NS; i++)
                if (m_win < 0 && m_pend[i] && m_mask[i]) m_win = i;
            if (m_mode == 0 && m_win >= 0) begin
                m_mode = 1;
                m_id   = m_win;
            end else if (m_take) begin
                m_mode = 2;
                m_epc  = int'(take_pc);
            end else if (m_mode == 2 && iret) begin
                m_mode = 0;
            end
            for (int i = 0; i < NS; i++) begin
                if (EDGE[i]) begin
                    if (src_int[i] && !m_hist[i]) m_pend[i] = 1'b1;
                    else if (m_take && m_id == i) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = src_int[i];
                end
                m_hist[i] = src_int[i];
            end
            if (mask_we) m_mask = mask_wdata;
        end
        #1;
        chk("m_req", int_req, (m_mode == 1));
        chk("m_svc", in_service, (m_mode == 2));
        chk("m_ack", src_ack, m_ack);
        chk("m_retpc", ret_pc, m_epc);
        if (m_mode == 1) begin
            chk("m_id", int_id, m_id);
            chk("m_vec", int_vec, (32'h40 + m_id * 4) & 32'hFFFF);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        cyc();
        mask_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; src_int = '0; mask_we = 1'b0; mask_wdata = '0;
        int_take = 1'b0; take_pc = '0; iret = 1'b0;
        cyc(); cyc();
        chk("rst_req", int_req, 0);
        chk("rst_ack", src_ack, 0);
        chk("rst_svc", in_service, 0);
        chk("rst_retpc", ret_pc, 0);
        chk("rst_vec", int_vec, 0);
        rst = 1'b1;

        // Edge source 0: two-cycle latency, take, ack pulse, iret
        wr_mask(4'b0001);
        src_int = 4'b0001; cyc(); src_int = 4'b0000;
        chk("t1_lat1", int_req, 0);
        cyc();
        chk("t1_req", int_req, 1);
        chk("t1_id", int_id, 0);
        chk("t1_vec", int_vec, 16'h0040);
        int_take = 1'b1; take_pc = 16'h0123; cyc(); int_take = 1'b0;
        chk("t1_ack", src_ack, 4'b0001);
        chk("t1_svc", in_service, 1);
        chk("t1_req_low", int_req, 0);
        chk("t1_retpc", ret_pc, 16'h0123);
        cyc();
        chk("t1_ack_once", src_ack, 0);
        iret = 1'b1; cyc(); iret = 1'b0;
        chk("t1_idle", in_service, 0);
        chk("t1_retpc_iret", ret_pc, 16'h0123);
        cyc(); cyc();
        chk("t1_norepeat", int_req, 0);

        // Level sources 2 and 3: priority, then the lower one after iret
        src_int = 4'b1100;
        wr_mask(4'b1100);
        cyc();
        chk("t2_id", int_id, 2);
        chk("t2_vec", int_vec, 16'h0048);
        int_take = 1'b1; take_pc = 16'h0400; cyc(); int_take = 1'b0;
        chk("t2_ack", src_ack, 4'b0100);
        src_int = 4'b1000; iret = 1'b1; cyc(); iret = 1'b0;
        cyc();
        chk("t2_req3", int_req, 1);
        chk("t2_id3", int_id, 3);
        chk("t2_vec3", int_vec, 16'h004C);
        src_int = 4'b0000; int_take = 1'b1; cyc(); int_take = 1'b0;
        chk("t2_ack3", src_ack, 4'b1000);
        iret = 1'b1; cyc(); iret = 1'b0;
        cyc(); cyc();
        chk("t2_quiet", int_req, 0);

        // Edge on masked source 1, enabled later
        wr_mask(4'b0000);
        src_int = 4'b0010; cyc(); src_int = 4'b0000;
        cyc(); cyc();
        chk("t3_masked", int_req, 0);
        wr_mask(4'b0010);
        chk("t3_wr_lat1", int_req, 0);
        cyc();
        chk("t3_req", int_req, 1);
        chk("t3_id", int_id, 1);
        chk("t3_vec", int_vec, 16'h0044);
        int_take = 1'b1; cyc(); int_take = 1'b0;
        chk("t3_ack", src_ack, 4'b0010);
        iret = 1'b1; cyc(); iret = 1'b0;
        cyc(); cyc();
        chk("t3_quiet", int_req, 0);

        // New edge coinciding with the take-time clear
        wr_mask(4'b0001);
        src_int = 4'b0001; cyc(); src_int = 4'b0000;
        cyc();
        chk("t4_req", int_req, 1);
        int_take = 1'b1; take_pc = 16'h0200; src_int = 4'b0001; cyc();
        int_take = 1'b0; src_int = 4'b0000;
        chk("t4_ack", src_ack, 4'b0001);
        chk("t4_svc", in_service, 1);
        cyc();
        iret = 1'b1; cyc(); iret = 1'b0;
        chk("t4_idle_req", int_req, 0);
        chk("t4_idle_svc", in_service, 0);
        cyc();
        chk("t4_again", int_req, 1);
        chk("t4_again_id", int_id, 0);
        int_take = 1'b1; take_pc = 16'h0300; cyc(); int_take = 1'b0;
        iret = 1'b1; cyc(); iret = 1'b0;
        cyc(); cyc();
        chk("t4_done", int_req, 0);

        // Reset while in service
        src_int = 4'b0001; cyc(); src_int = 4'b0000;
        cyc();
        int_take = 1'b1; take_pc = 16'hBEEF; cyc(); int_take = 1'b0;
        chk("t5_retpc", ret_pc, 16'hBEEF);
        chk("t5_svc", in_service, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_req", int_req, 0);
        chk("t5_rst_ack", src_ack, 0);
        chk("t5_rst_svc", in_service, 0);
        chk("t5_rst_retpc", ret_pc, 0);
        cyc(); rst = 1'b1;
        cyc();
        chk("t5_after", int_req, 0);
        src_int = 4'b0001; cyc(); src_int = 4'b0000;
        cyc(); cyc();
        chk("t5_nomask", int_req, 0);

        // int_take in IDLE and iret in REQ are ignored
        int_take = 1'b1; take_pc = 16'h5555; cyc(); int_take = 1'b0;
        chk("t6_take_svc", in_service, 0);
        chk("t6_take_retpc", ret_pc, 0);
        chk("t6_take_req", int_req, 0);
        wr_mask(4'b0001);
        cyc();
        chk("t6_req", int_req, 1);
        iret = 1'b1; cyc(); iret = 1'b0;
        chk("t6_iret_req", int_req, 1);
        chk("t6_iret_svc", in_service, 0);
        chk("t6_iret_id", int_id, 0);
        int_take = 1'b1; cyc(); int_take = 1'b0;
        iret = 1'b1; cyc(); iret = 1'b0;

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) src_int[b] = ~src_int[b];
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom);
            int_take   = ($urandom_range(0, 2) == 0);
            take_pc    = 16'($urandom);
            iret       = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 399) != 0);
            cyc();
        end
        rst = 1'b1; src_int = '0; mask_we = 1'b0; int_take = 1'b0; iret = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised multi-source interrupt controller that replaces the single ipu_int/int_ack pair on the processor's fetch stage. It latches NUM_SRC interrupt sources (edge- or level-sensitive per source), masks and prioritises them, and raises one vectored request to fetch. It holds the interrupted PC for the return path and acknowledges the serviced source. It sits between the peripherals (IPU, switches, timers) and the fetch stage of the 5-stage core.

## Interface
- NUM_SRC, 4: number of interrupt sources (1..16).
- PC_W, 16: PC width, matching the fetch PC.
- EDGE_MASK, 4'b0001: per-source mode; 1 = rising-edge latched, 0 = level.
- VEC_BASE, 16'h0040: vector of source 0.
- VEC_STRIDE, 16'h0004: vector spacing between sources.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- src_int  in  NUM_SRC  raw interrupt lines, already synchronous to clk.
- src_ack  out  NUM_SRC  one-cycle acknowledge to the serviced source.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  NUM_SRC  new mask; 1 = enabled.
- int_req  out  1  vectored request to fetch.
- int_id  out  4  index of the requested source.
- int_vec  out  PC_W  target PC for the request.
- int_take  in  1  fetch redirects to int_vec this cycle.
- take_pc  in  PC_W  PC to resume at, valid with int_take.
- iret  in  1  return-from-interrupt retired.
- ret_pc  out  PC_W  saved PC (epc).
- in_service  out  1  handler active.

## Operation
- Reset value of every output is 0; mask, pending, epc, edge history and the state register also reset to 0. Reset state is IDLE.
- Pending:
  - Edge source: set on src_int 0→1 (one-flop history), cleared in the cycle after int_take selects it. If a new edge coincides with the clear, set wins.
  - Level source: pending mirrors the registered src_int and is never cleared by the controller.
- Eligible = pending & mask. Priority is fixed, lowest index highest.
- States:
  - IDLE: if any eligible bit, go to REQ. The winning id and vector are latched in the same edge.
  - REQ: int_req=1, and int_id/int_vec stay frozen while waiting. Mask writes or lower-priority arrivals do not change or withdraw the request. int_take moves to SERVICE.
  - SERVICE: in_service=1, no new requests (no nesting). iret moves to IDLE.
- On the take edge:
  - epc ← take_pc.
  - src_ack[id] pulses for exactly one cycle (the first SERVICE cycle).
  - An edge source's pending bit is cleared.
- ret_pc = epc at all times. It is valid to fetch from the iret cycle onward.
- int_take outside REQ is ignored. iret outside SERVICE is ignored.
- Mask write takes effect on the next edge; mask_wdata bits above NUM_SRC are ignored.
- int_vec = VEC_BASE + id*VEC_STRIDE, computed mod 2^PC_W.
- Asserting reset mid-REQ or mid-SERVICE drops every output within the same cycle (asynchronous) and discards pending, epc and mask.

## Timing
- Edge seen on src_int in cycle t → pending at t+1 → int_req high at t+2. Latency is 2 cycles with the source already enabled.
- int_take in cycle k → in_service and src_ack high at k+1; int_req low at k+1.
- iret in cycle m → IDLE at m+1 → earliest new int_req at m+2.
- All outputs are registered or derived only from registers; there is no combinational path from inputs to outputs.

## Structure
- The shared processor defines file holds:
  - state encodings IRQ_IDLE=2'd0, IRQ_REQ=2'd1, IRQ_SVC=2'd2;
  - default VEC_BASE and VEC_STRIDE;
  - the 4-bit id width.
- One sub-module, irq_prio_enc: combinational lowest-index-first encoder, NUM_SRC-wide, with any/id outputs.
- Flops reuse the existing dflop cell style (register arrays); only the state register and pending logic are custom.

## Test plan
- Source 0 edge mode, mask=4'b0001, pulse src_int[0] at t → int_req=1, int_id=0, int_vec=16'h0040 at t+2. int_take with take_pc=16'h0123 → src_ack=4'b0001 for one cycle, ret_pc=16'h0123. iret → IDLE, and no repeat request.
- src_int[2] and src_int[3] both set (level), mask=4'b1100 → int_id=2, int_vec=16'h0048. After iret with src_int[2] dropped → int_id=3, int_vec=16'h004C.
- Source 1 masked while its edge arrives → no int_req. mask_we with 4'b0010 later → int_req two cycles after the write.
- New edge on source 0 in the same cycle the take clears it → pending stays set, and a second request follows two cycles after iret.
- Reset asserted in SERVICE → int_req, src_ack, in_service, ret_pc all 0 immediately. After release, no request until a fresh edge and a mask write.
- int_take in IDLE and iret in REQ → ignored; the state and outputs are unchanged.
